test_sequencer: RTL and testbench
=================================

# test_sequencer

Hardware test runner for the lab designs. It runs `NUM_TESTS` test-case units in index order over a start/done/pass handshake and guards each one with a per-test watchdog. It aggregates the results into an overall pass flag, a failure mask and a pass count. It sits between the board-level control (button or UART command) and the student test units, and is the synthesisable, multi-test successor of the simulation-only single-suite runner.

## Interface
Parameters:
- `NUM_TESTS`, 4: number of test-case units; legal range 1..32.
- `TIMEOUT_W`, 16: width of the watchdog counter and of the `timeout_cycles` input.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to run the whole sequence.
- `stop_on_fail`  in  1  mode bit, sampled with `start`. 1 means abort after the first failing test.
- `timeout_cycles`  in  TIMEOUT_W  watchdog limit per test, sampled with `start`. 0 disables the watchdog.
- `tc_start`  out  NUM_TESTS  one-hot start pulse to the current test unit.
- `tc_done`  in  NUM_TESTS  per-unit completion strobe.
- `tc_pass`  in  NUM_TESTS  per-unit verdict, qualified by `tc_done`.
- `busy`  out  1  a sequence is in progress.
- `done`  out  1  results are valid; held until the next accepted `start`.
- `test_passed`  out  1  all executed tests passed and none was skipped.
- `fail_mask`  out  NUM_TESTS  bit i set means test i failed or timed out.
- `timeout_mask`  out  NUM_TESTS  bit i set means test i timed out.
- `skip_mask`  out  NUM_TESTS  bit i set means test i was not run because of an abort.
- `pass_count`  out  $clog2(NUM_TESTS+1)  number of passing tests.
- `cur_idx`  out  IDX_W  index of the current or last test. IDX_W = max(1, $clog2(NUM_TESTS)).

## Operation
- FSM states are IDLE, LAUNCH, WAIT, ADVANCE and REPORT.
- **IDLE.** `start` moves the FSM to LAUNCH. On that move the block:
  - clears all masks and `pass_count`;
  - sets `cur_idx` to 0;
  - latches `stop_on_fail` and `timeout_cycles`.
- **LAUNCH.** The block drives `tc_start[cur_idx]` high for exactly one cycle, clears the watchdog, then goes to WAIT.
- **WAIT.** The watchdog increments every cycle.
  - If `tc_done[cur_idx]` is 1: a 1 on `tc_pass[cur_idx]` increments `pass_count`; a 0 sets `fail_mask[cur_idx]`.
  - Else, if the watchdog is nonzero and reaches `timeout_cycles`: set `fail_mask[cur_idx]` and `timeout_mask[cur_idx]`.
  - Either event moves the FSM to ADVANCE.
  - A `tc_done` that arrives together with the watchdog limit counts as completion; the timeout is not flagged.
  - `tc_done` and `tc_pass` bits for any index other than `cur_idx` are ignored in every state.
- **ADVANCE.**
  - If the test just run failed and the latched `stop_on_fail` is 1: set `skip_mask` for all indices above `cur_idx`, then go to REPORT.
  - Else, if `cur_idx` equals NUM_TESTS-1: go to REPORT.
  - Else: increment `cur_idx` and go to LAUNCH.
- **REPORT.** The block asserts `done` and computes `test_passed = (fail_mask == 0) && (skip_mask == 0)`. It stays in REPORT. A `start` received in REPORT behaves exactly like a `start` in IDLE.
- `busy` is 1 in LAUNCH, WAIT and ADVANCE.
- `start` is ignored while `busy` is 1.

## Timing
- Reset values: state IDLE, all outputs 0, `cur_idx` 0.
- Reset is asynchronous. Asserting it mid-sequence aborts immediately and does not produce a pulse on `tc_start`.
- From `start` in cycle 0:
  - cycle 1 is LAUNCH, with `tc_start[0]` high and `busy` high;
  - cycle 2 is the first WAIT cycle.
- `tc_done` arriving in the first WAIT cycle is accepted. The minimum per-test duration is therefore 3 cycles: LAUNCH, WAIT, ADVANCE.
- With every test answering in its first WAIT cycle, `done` rises at cycle 3·NUM_TESTS + 1.
- A timeout is flagged in the WAIT cycle where the watchdog equals `timeout_cycles`, i.e. `timeout_cycles` cycles after LAUNCH.
- The watchdog saturates and does not wrap. With `timeout_cycles` = 0 the block waits indefinitely.
- All outputs are registered; none is driven combinationally from an input.

## Structure
- Package `test_seq_pkg` holds:
  - the `state_t` enum;
  - the `verdict_t` enum {PASS, FAIL, TIMEOUT, SKIP};
  - the function `idx_w(n)`.
- Sub-module `test_seq_watchdog` takes `clk`, `rst_n`, `clear`, `en` and `limit`, and outputs `expired`. It is a saturating counter parameterised by TIMEOUT_W.
- The FSM, masks and counters live in `test_sequencer`.

## Test plan
- All four tests pass on the first WAIT cycle:
  - `done` at cycle 13;
  - `test_passed`=1, `pass_count`=4, all masks 0.
- Test 2 reports fail, `stop_on_fail`=0:
  - `fail_mask`=4'b0100, `pass_count`=3;
  - `test_passed`=0, `skip_mask`=0.
- Test 1 fails, `stop_on_fail`=1:
  - `fail_mask`=4'b0010, `skip_mask`=4'b1100;
  - `pass_count`=1, `tc_start[2]` never pulses.
- `timeout_cycles`=5 and test 0 never answers:
  - `timeout_mask[0]`=1, flagged 5 cycles after LAUNCH;
  - the sequence then continues with test 1.
- `tc_done[0]` coincides with the watchdog limit while `tc_pass[0]`=1: test 0 counts as passed and `timeout_mask` stays 0.
- Reset mid-WAIT of test 2, then `start`: all outputs return to 0 at once, and the full sequence rerun from index 0 gives correct results.

Source files
------------

// File: rtl/test_seq_pkg.sv
// Shared types and helpers for the hardware test sequencer.
// Imported by the sequencer top, its watchdog and the bench.
package test_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ADVANCE,
        REPORT
    } state_t;

    typedef enum logic [1:0] {
        PASS,
        FAIL,
        TIMEOUT,
        SKIP
    } verdict_t;

    // Index width for n test units, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Start/done/pass handshake between the sequencer and the test-case units.
// Handshake: tc_start[i] is a one-cycle pulse launching unit i; unit i answers with
// a one-cycle tc_done[i] strobe, and tc_pass[i] is only meaningful in that same cycle.
interface test_sequencer_if #(
    parameter int NUM_TESTS = 4
);
    logic [NUM_TESTS-1:0] tc_start;
    logic [NUM_TESTS-1:0] tc_done;
    logic [NUM_TESTS-1:0] tc_pass;

    modport master (
        output tc_start,
        input  tc_done,
        input  tc_pass
    );

    modport slave (
        input  tc_start,
        output tc_done,
        output tc_pass
    );
endinterface

// File: rtl/test_seq_watchdog.sv
// Saturating per-test watchdog; expired fires in the enabled cycle whose
// incremented count equals a nonzero limit.
module test_seq_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;
    logic [TIMEOUT_W-1:0] cnt_inc;

    always_comb begin
        // Hold at all-ones instead of wrapping back through the limit.
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
        end
    end

    assign expired = en && !clear && (limit != '0) && (cnt_inc == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Runs NUM_TESTS test units in index order with a per-test watchdog and
// aggregates pass/fail/timeout/skip results; every output is registered.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int NUM_TESTS = 4,
    parameter int TIMEOUT_W = 16,
    localparam int IDX_W = idx_w(NUM_TESTS),
    localparam int CNT_W = $clog2(NUM_TESTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop_on_fail,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    test_sequencer_if.master     tc_if,
    output logic                 busy,
    output logic                 done,
    output logic                 test_passed,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask,
    output logic [NUM_TESTS-1:0] skip_mask,
    output logic [CNT_W-1:0]     pass_count,
    output logic [IDX_W-1:0]     cur_idx,
    output state_t               state_dbg
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
    logic [NUM_TESTS-1:0] fail_q, fail_d;
    logic [NUM_TESTS-1:0] tmo_q, tmo_d;
    logic [NUM_TESTS-1:0] skip_q, skip_d;
    logic [CNT_W-1:0]     pcnt_q, pcnt_d;
    logic                 sof_q, sof_d;
    logic [TIMEOUT_W-1:0] limit_q, limit_d;
    logic [NUM_TESTS-1:0] tc_start_q, tc_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 passed_q, passed_d;
    logic                 wd_clear;
    logic                 wd_en;
    logic                 wd_expired;

    test_seq_watchdog #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .en     (wd_en),
        .limit  (limit_q),
        .expired(wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        fail_d    = fail_q;
        tmo_d     = tmo_q;
        skip_d    = skip_q;
        pcnt_d    = pcnt_q;
        sof_d     = sof_q;
        limit_d   = limit_q;
        wd_clear  = 1'b0;
        wd_en     = 1'b0;

        case (state_q)
            IDLE, REPORT: begin
                if (start) begin
                    state_d   = LAUNCH;
                    cur_idx_d = '0;
                    fail_d    = '0;
                    tmo_d     = '0;
                    skip_d    = '0;
                    pcnt_d    = '0;
                    sof_d     = stop_on_fail;
                    limit_d   = timeout_cycles;
                end
            end
            LAUNCH: begin
                wd_clear = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                wd_en = 1'b1;
                // Completion wins over a watchdog expiry in the same cycle.
                if (tc_if.tc_done[cur_idx_q]) begin
                    if (tc_if.tc_pass[cur_idx_q]) begin
                        pcnt_d = pcnt_q + CNT_W'(1);
                    end else begin
                        fail_d[cur_idx_q] = 1'b1;
                    end
                    state_d = ADVANCE;
                end else if (wd_expired) begin
                    fail_d[cur_idx_q] = 1'b1;
                    tmo_d[cur_idx_q]  = 1'b1;
                    state_d           = ADVANCE;
                end
            end
            ADVANCE: begin
                if (fail_q[cur_idx_q] && sof_q) begin
                    for (int i = 0; i < NUM_TESTS; i++) begin
                        if (i > int'(cur_idx_q)) skip_d[i] = 1'b1;
                    end
                    state_d = REPORT;
                end else if (cur_idx_q == IDX_W'(NUM_TESTS - 1)) begin
                    state_d = REPORT;
                end else begin
                    cur_idx_d = cur_idx_q + IDX_W'(1);
                    state_d   = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        tc_start_d = '0;
        if (state_d == LAUNCH) tc_start_d[cur_idx_d] = 1'b1;
        busy_d   = (state_d == LAUNCH) || (state_d == WAIT) || (state_d == ADVANCE);
        done_d   = (state_d == REPORT);
        passed_d = done_d && (fail_d == '0) && (skip_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_idx_q  <= '0;
            fail_q     <= '0;
            tmo_q      <= '0;
            skip_q     <= '0;
            pcnt_q     <= '0;
            sof_q      <= 1'b0;
            limit_q    <= '0;
            tc_start_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            passed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            fail_q     <= fail_d;
            tmo_q      <= tmo_d;
            skip_q     <= skip_d;
            pcnt_q     <= pcnt_d;
            sof_q      <= sof_d;
            limit_q    <= limit_d;
            tc_start_q <= tc_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            passed_q   <= passed_d;
        end
    end

    assign tc_if.tc_start = tc_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign test_passed    = passed_q;
    assign fail_mask      = fail_q;
    assign timeout_mask   = tmo_q;
    assign skip_mask      = skip_q;
    assign pass_count     = pcnt_q;
    assign cur_idx        = cur_idx_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: a per-run timeline model (launch/event cycle and verdict
// per test) yields expected outputs for every cycle; randomized plus directed runs.
module tb_test_sequencer;
    import test_seq_pkg::*;

    localparam int N    = 4;
    localparam int TW   = 16;
    localparam int MAXC = 256;
    localparam int TAIL = 3;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop_on_fail;
    logic [TW-1:0] timeout_cycles;
    logic          busy, done, test_passed;
    logic [N-1:0]  fail_mask, timeout_mask, skip_mask;
    logic [2:0]    pass_count;
    logic [1:0]    cur_idx;
    state_t        state_dbg;

    test_sequencer_if #(.NUM_TESTS(N)) tc_if ();

    test_sequencer #(
        .NUM_TESTS(N),
        .TIMEOUT_W(TW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop_on_fail  (stop_on_fail),
        .timeout_cycles(timeout_cycles),
        .tc_if         (tc_if.master),
        .busy          (busy),
        .done          (done),
        .test_passed   (test_passed),
        .fail_mask     (fail_mask),
        .timeout_mask  (timeout_mask),
        .skip_mask     (skip_mask),
        .pass_count    (pass_count),
        .cur_idx       (cur_idx),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_c   = 0;
    bit chk_en   = 1'b0;

    int         first_done, tmo0_rise, start1_cyc;
    logic [N-1:0] saw_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- run plan and timeline model ----------------
    int       p_delay[N];   // response cycles after LAUNCH, 0 = never answers
    bit       p_pass[N];
    int       p_T;
    bit       p_sof;

    int       m_li[N], m_ei[N], m_R;
    bit       m_ran[N], m_resp[N];
    verdict_t m_v[N];

    // Expected queue-free per-cycle scoreboard, indexed by cycle within the run.
    logic [N-1:0] e_start[MAXC], e_fail[MAXC], e_tmo[MAXC], e_skip[MAXC];
    bit           e_busy[MAXC], e_done[MAXC], e_passed[MAXC];
    int           e_pcnt[MAXC], e_idx[MAXC];

    task automatic build_model();
        int l;
        logic [N-1:0] s, f, t, k;
        int pc, ix;
        bit allpass;
        l   = 1;
        m_R = -1;
        for (int i = 0; i < N; i++) begin
            m_ran[i] = 0; m_resp[i] = 0; m_v[i] = SKIP; m_li[i] = -10; m_ei[i] = -10;
        end
        // Each test: LAUNCH at l, decisive WAIT cycle at e, ADVANCE at e+1.
        for (int i = 0; i < N; i++) begin
            m_ran[i]  = 1;
            m_li[i]   = l;
            m_resp[i] = (p_delay[i] > 0) && (p_T == 0 || p_delay[i] <= p_T);
            if (m_resp[i]) begin
                m_ei[i] = l + p_delay[i];
                m_v[i]  = p_pass[i] ? PASS : FAIL;
            end else begin
                m_ei[i] = l + p_T;
                m_v[i]  = TIMEOUT;
            end
            if ((m_v[i] != PASS && p_sof) || i == N - 1) begin
                m_R = m_ei[i] + 2;
                break;
            end
            l = m_ei[i] + 2;
        end
        allpass = 1;
        for (int i = 0; i < N; i++) if (m_v[i] != PASS) allpass = 0;
        for (int c = 1; c <= m_R + TAIL; c++) begin
            s = '0; f = '0; t = '0; k = '0; pc = 0; ix = 0;
            for (int i = 0; i < N; i++) begin
                if (m_ran[i] && c == m_li[i]) s[i] = 1'b1;
                if (m_ran[i] && m_li[i] <= c) ix = i;
                if (m_ran[i] && c > m_ei[i]) begin
                    if (m_v[i] == PASS) pc++;
                    else begin
                        f[i] = 1'b1;
                        if (m_v[i] == TIMEOUT) t[i] = 1'b1;
                    end
                end
                if (m_v[i] == SKIP && c >= m_R) k[i] = 1'b1;
            end
            e_start[c]  = s;
            e_fail[c]   = f;
            e_tmo[c]    = t;
            e_skip[c]   = k;
            e_pcnt[c]   = pc;
            e_idx[c]    = ix;
            e_busy[c]   = (c < m_R);
            e_done[c]   = (c >= m_R);
            e_passed[c] = (c >= m_R) && allpass;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input int c);
        logic [N-1:0] d, p;
        start          = (c == 0) ? 1'b1 : ((c < m_R && $urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        stop_on_fail   = (c == 0) ? p_sof : 1'($urandom_range(0, 1));
        timeout_cycles = (c == 0) ? TW'(p_T) : TW'($urandom_range(0, 65535));
        for (int j = 0; j < N; j++) begin
            if (m_ran[j] && c >= m_li[j] && c <= m_ei[j] + 1) begin
                d[j] = m_resp[j] && (c == m_li[j] + p_delay[j]);
                p[j] = d[j] ? p_pass[j] : 1'($urandom_range(0, 1));
            end else begin
                d[j] = ($urandom_range(0, 3) == 0);
                p[j] = 1'($urandom_range(0, 1));
            end
        end
        tc_if.tc_done = d;
        tc_if.tc_pass = p;
    endtask

    task automatic run_seq(input int stop_at);
        chk_en = 1'b0;
        build_model();
        last_c     = (stop_at > 0) ? stop_at : m_R + TAIL;
        first_done = -1;
        tmo0_rise  = -1;
        start1_cyc = -1;
        saw_start  = '0;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            cyc    = c;
            chk_en = 1'b1;
            drive(c);
        end
        @(negedge clk);
    endtask

    task automatic set_plan(input int d0, d1, d2, d3, input bit q0, q1, q2, q3,
                            input int t, input bit sof);
        p_delay[0] = d0; p_delay[1] = d1; p_delay[2] = d2; p_delay[3] = d3;
        p_pass[0]  = q0; p_pass[1]  = q1; p_pass[2]  = q2; p_pass[3]  = q3;
        p_T = t;
        p_sof = sof;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en && cyc >= 1 && cyc <= last_c) begin
            chk("tc_start", tc_if.tc_start, e_start[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("done", done, e_done[cyc]);
            chk("test_passed", test_passed, e_passed[cyc]);
            chk("fail_mask", fail_mask, e_fail[cyc]);
            chk("timeout_mask", timeout_mask, e_tmo[cyc]);
            chk("skip_mask", skip_mask, e_skip[cyc]);
            chk("pass_count", pass_count, e_pcnt[cyc]);
            chk("cur_idx", cur_idx, e_idx[cyc]);
            if (done === 1'b1 && first_done < 0) first_done = cyc;
            if (timeout_mask[0] === 1'b1 && tmo0_rise < 0) tmo0_rise = cyc;
            if (tc_if.tc_start[1] === 1'b1 && start1_cyc < 0) start1_cyc = cyc;
            saw_start = saw_start | tc_if.tc_start;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tc_start"}, tc_if.tc_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_passed"}, test_passed, 0);
        chk({tag, "_masks"}, {fail_mask, timeout_mask, skip_mask}, 0);
        chk({tag, "_pcnt"}, pass_count, 0);
        chk({tag, "_idx"}, cur_idx, 0);
        chk({tag, "_state"}, state_dbg, IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; stop_on_fail = 1'b0; timeout_cycles = '0;
        tc_if.tc_done = '0; tc_if.tc_pass = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // All pass in first WAIT cycle.
        set_plan(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        run_seq(0);
        chk("s1_done_cycle", first_done, 13);
        chk("s1_passed", test_passed, 1);
        chk("s1_pcnt", pass_count, 4);
        chk("s1_masks", {fail_mask, timeout_mask, skip_mask}, 0);

        // Test 2 fails, no abort.
        set_plan(2, 1, 3, 2, 1, 1, 0, 1, 0, 0);
        run_seq(0);
        chk("s2_fail", fail_mask, 4'b0100);
        chk("s2_pcnt", pass_count, 3);
        chk("s2_passed", test_passed, 0);
        chk("s2_skip", skip_mask, 0);

        // Test 1 fails with abort.
        set_plan(1, 2, 1, 1, 1, 0, 1, 1, 0, 1);
        run_seq(0);
        chk("s3_fail", fail_mask, 4'b0010);
        chk("s3_skip", skip_mask, 4'b1100);
        chk("s3_pcnt", pass_count, 1);
        chk("s3_started", saw_start, 4'b0011);

        // Test 0 never answers, watchdog of 5.
        set_plan(0, 2, 2, 2, 1, 1, 1, 1, 5, 0);
        run_seq(0);
        chk("s4_tmo_visible", tmo0_rise, 7);
        chk("s4_next_launch", start1_cyc, 8);
        chk("s4_tmo", timeout_mask, 4'b0001);
        chk("s4_fail", fail_mask, 4'b0001);
        chk("s4_pcnt", pass_count, 3);

        // Completion coincides with the watchdog limit.
        set_plan(3, 1, 1, 1, 1, 1, 1, 1, 3, 1);
        run_seq(0);
        chk("s5_tmo", timeout_mask, 0);
        chk("s5_pcnt", pass_count, 4);
        chk("s5_passed", test_passed, 1);

        // Reset mid-WAIT of test 2 (launched at cycle 9), then a clean rerun.
        set_plan(2, 2, 2, 2, 1, 1, 1, 1, 0, 0);
        run_seq(10);
        chk("s6_pre_idx", cur_idx, 2);
        chk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        tc_if.tc_done = '0;
        #1;
        chk_all_zero("s6_async");
        repeat (2) begin
            @(negedge clk);
            chk("s6_hold_tc_start", tc_if.tc_start, 0);
        end
        rst_n = 1'b1;
        set_plan(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        run_seq(0);
        chk("s6_done_cycle", first_done, 13);
        chk("s6_pcnt", pass_count, 4);
        chk("s6_passed", test_passed, 1);

        // Randomized plans.
        for (int r = 0; r < 20; r++) begin
            p_T   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8);
            p_sof = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                if (p_T != 0 && $urandom_range(0, 4) == 0) p_delay[i] = 0;
                else p_delay[i] = $urandom_range(1, 10);
                p_pass[i] = ($urandom_range(0, 3) != 0);
            end
            run_seq(0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
